// File: rtl/oam_dma_if.sv
// CPU-write, source-read and OAM-write signals of the OAM DMA engine.
// Latency: none, this is wiring only.
// Backpressure: none; the read side has a fixed latency and the OAM side always accepts.
interface oam_dma_if;
    logic        iCpuWe;
    logic [15:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic [7:0]  oDmaReg;
    logic        oDmaActive;
    logic        oDmaReadRequest;
    logic [15:0] oDmaReadAddr;
    logic [7:0]  iDmaReadData;
    logic        oOamWe;
    logic [7:0]  oOamAddr;
    logic [7:0]  oOamData;
    logic        oDone;

    // DMA engine side
    modport master (
        input  iCpuWe, iCpuAddr, iCpuData, iDmaReadData,
        output oDmaReg, oDmaActive, oDmaReadRequest, oDmaReadAddr,
               oOamWe, oOamAddr, oOamData, oDone
    );

    // CPU / memory / OAM side
    modport slave (
        output iCpuWe, iCpuAddr, iCpuData, iDmaReadData,
        input  oDmaReg, oDmaActive, oDmaReadRequest, oDmaReadAddr,
               oOamWe, oOamAddr, oOamData, oDone
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: an FF46 write copies OAM_BYTES bytes from the selected source page into OAM.
// Latency: first read in the cycle after the trigger edge; each OAM write trails its read by READ_LATENCY.
// Backpressure: none; one read per cycle into fixed-latency memory, a new FF46 write restarts the copy.
module oam_dma #(
    parameter int OAM_BYTES    = 160,
    parameter int READ_LATENCY = 1
) (
    input logic       iClock,
    input logic       iReset,
    oam_dma_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    state_t state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    logic [7:0]  page_d;

    // Read-tag pipeline: one {valid, index} per outstanding read, aligned with the memory latency.
    logic [READ_LATENCY-1:0]       pvld_q, pvld_d;
    logic [READ_LATENCY-1:0][7:0]  pidx_q, pidx_d;

    logic        req_q, req_d;
    logic [15:0] raddr_q, raddr_d;
    logic        active_q, active_d;
    logic        done_q, done_d;

    logic        trigger;
    logic        last_wr;

    // Next-state, pipeline advance and registered-output next values
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dma_reg_d = dma_reg_q;
        pvld_d    = '0;
        pidx_d    = '0;

        trigger = bus.iCpuWe && (bus.iCpuAddr == 16'hFF46);
        last_wr = pvld_q[READ_LATENCY-1] && (pidx_q[READ_LATENCY-1] == LAST_IDX);

        // Each XFER cycle issues a read whose index enters stage 0.
        pvld_d[0] = (state_q == S_XFER);
        pidx_d[0] = idx_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pvld_d[i] = pvld_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        case (state_q)
            S_IDLE: ;
            S_XFER: begin
                // Index saturates at the last byte; the next cycle starts draining.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_DRAIN: begin
                // Draining ends with the final OAM write.
                if (last_wr) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completion pulse follows the final write unless a restart lands on it.
        done_d = last_wr;

        // FF46 write wins over everything: reload, flush pending writes, start over.
        if (trigger) begin
            dma_reg_d = bus.iCpuData;
            state_d   = S_XFER;
            idx_d     = '0;
            pvld_d    = '0;
            done_d    = 1'b0;
        end

        // Pages E0..FF alias the work-RAM echo back down to C0..DF.
        page_d   = (dma_reg_d <= 8'hDF) ? dma_reg_d : (dma_reg_d - 8'h20);
        req_d    = (state_d == S_XFER);
        raddr_d  = {page_d, idx_d};
        active_d = (state_d != S_IDLE);
    end

    // FSM state, index and source-page register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            dma_reg_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dma_reg_q <= dma_reg_d;
        end
    end

    // Read-tag shift pipeline
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            pvld_q <= '0;
            pidx_q <= '0;
        end else begin
            pvld_q <= pvld_d;
            pidx_q <= pidx_d;
        end
    end

    // Registered request, address, activity and completion outputs
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            req_q    <= 1'b0;
            raddr_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            req_q    <= req_d;
            raddr_q  <= raddr_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.oDmaReg         = dma_reg_q;
    assign bus.oDmaActive      = active_q;
    assign bus.oDmaReadRequest = req_q;
    assign bus.oDmaReadAddr    = raddr_q;
    assign bus.oOamWe          = pvld_q[READ_LATENCY-1];
    assign bus.oOamAddr        = pidx_q[READ_LATENCY-1];
    assign bus.oOamData        = bus.iDmaReadData;
    assign bus.oDone           = done_q;

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter OAM_BYTES, default 160, sets the number of bytes copied per transfer.
REQ-002 Parameter READ_LATENCY, default 1, legal range 1..3; it is the cycles from oDmaReadAddr presented to iDmaReadData valid.
REQ-003 iClock  in  1  sole clock, rising edge.
REQ-004 iReset  in  1  asynchronous, active-low reset.
REQ-005 iCpuWe  in  1  CPU write strobe, same as MMU.
REQ-006 iCpuAddr  in  16  CPU address.
REQ-007 iCpuData  in  8  CPU write data.
REQ-008 oDmaReg  out  8  FF46 readback value, i.e. the last written source page.
REQ-009 oDmaActive  out  1  transfer in progress; the MMU blocks CPU OAM access while high.
REQ-010 oDmaReadRequest  out  1  a source read is issued this cycle.
REQ-011 oDmaReadAddr  out  16  source byte address.
REQ-012 iDmaReadData  in  8  source data, valid READ_LATENCY cycles after the matching request.
REQ-013 oOamWe  out  1  OAM write strobe.
REQ-014 oOamAddr  out  8  OAM byte index, 0..OAM_BYTES-1.
REQ-015 oOamData  out  8  OAM write data; combinationally equal to iDmaReadData.
REQ-016 oDone  out  1  one-cycle pulse when a transfer completes.

Function
REQ-017 Trigger: a rising edge with iCpuWe=1 and iCpuAddr=16'hFF46 loads oDmaReg<=iCpuData and enters XFER with index 0.
REQ-018 Source page: page = oDmaReg when oDmaReg<=8'hDF; otherwise page = oDmaReg-8'h20 (echo, E0->C0).
REQ-019 States: IDLE, XFER, DRAIN; the FSM is state-register based.
REQ-020 IDLE: no strobes asserted; oDmaActive=0.
REQ-021 XFER: every cycle, oDmaReadRequest=1 and oDmaReadAddr={page, index}; index increments by 1.
REQ-022 XFER -> DRAIN occurs in the cycle after the request with index OAM_BYTES-1; the index never exceeds OAM_BYTES-1 and does not wrap.
REQ-023 Each request pushes {valid, index} into a READ_LATENCY-deep shift pipeline.
REQ-024 Pipeline output valid drives oOamWe=1 and oOamAddr=index in the same cycle iDmaReadData is valid.
REQ-025 DRAIN lasts exactly READ_LATENCY cycles, then the FSM returns to IDLE.
REQ-026 oDone pulses for 1 cycle in the cycle after the final OAM write (oOamAddr=OAM_BYTES-1).
REQ-027 oDmaActive=1 from the first XFER cycle through the final OAM-write cycle inclusive: OAM_BYTES+READ_LATENCY cycles.
REQ-028 Exactly OAM_BYTES OAM writes occur per uninterrupted transfer, in ascending address order, with no gaps.
REQ-029 Restart: an FF46 write during XFER or DRAIN reloads oDmaReg, clears all pipeline valids (pending writes are dropped), resets the index to 0 and enters XFER; no oDone is produced for the aborted transfer.
REQ-030 Simultaneous events: an FF46 write in the same cycle as the last pipeline write lets that write complete, suppresses oDone, and restarts.
REQ-031 CPU writes to any address other than FF46 have no effect on the block.
REQ-032 All outputs are registered except oOamData, and except oOamWe and oOamAddr, which are driven directly from pipeline registers.

Reset
REQ-033 iReset=0 asynchronously forces state=IDLE, index=0, all pipeline valids=0 and oDmaReg=8'hFF.
REQ-034 During reset all strobes are 0, oDone=0 and oDmaActive=0.
REQ-035 Reset asserted mid-transfer aborts the transfer with no further OAM writes and no oDone.
REQ-036 The first trigger is accepted on the first rising edge after iReset deasserts.

Verification
REQ-037 Basic copy: write 8'hC0 to FF46 with latency-1 memory model -> reads C000..C09F over 160 cycles; OAM writes 0..159 with data=mem; oDone in cycle 162 after the trigger edge; oDmaActive high for 161 cycles.
REQ-038 Echo: write 8'hE1 -> oDmaReadAddr runs C100..C19F; oDmaReg reads 8'hE1.
REQ-039 Restart: write 8'hC0, then 8'hD0 at index 50 -> no oDone for the first transfer; reads restart at D000; OAM addresses 0..159 are rewritten with D0xx data; exactly one oDone.
REQ-040 Reset mid-transfer: drop iReset at index 80 -> outputs go idle immediately; oDmaReg=8'hFF; no oDone.
REQ-041 READ_LATENCY=3: the basic copy gives oDmaActive high for 163 cycles, and each OAM write has data equal to the read issued 3 cycles earlier.
REQ-042 Non-trigger: write to FF45 or FE00 in IDLE -> no state change and no strobes.
